// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter / deconvolver pair: data widths,
// the deconvolver FSM state encoding and the default filter coefficients.
package fir_pkg;

    localparam int SAMPLE_W = 8;   // recovered sample x and history width
    localparam int RESULT_W = 16;  // filtered sample y width
    localparam int ACC_W    = 20;  // signed accumulator width
    localparam int COEFF_W  = 8;   // tap coefficient width
    localparam int PROD_W   = COEFF_W + SAMPLE_W;

    // Default coefficients of the forward filter: y = x + 2x1 + 3x2 + 4x3
    localparam logic [COEFF_W-1:0] DEF_B0 = 8'd1;
    localparam logic [COEFF_W-1:0] DEF_B1 = 8'd2;
    localparam logic [COEFF_W-1:0] DEF_B2 = 8'd3;
    localparam logic [COEFF_W-1:0] DEF_B3 = 8'd4;

    // Tap index walks 1..3 while subtracting B1*h0, B2*h1, B3*h2
    localparam logic [1:0] TAP_FIRST = 2'd1;
    localparam logic [1:0] TAP_LAST  = 2'd3;

    // Largest accumulator value that is still a legal 8-bit sample
    localparam logic signed [ACC_W-1:0] ACC_X_MAX = ACC_W'(255);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/fir_mac_step.sv
// One multiply-subtract step of the deconvolver: result = acc - coeff*sample.
// Purely combinational; the top module time-multiplexes it across the taps.
module fir_mac_step
    import fir_pkg::*;
(
    input  logic signed [ACC_W-1:0]    acc,
    input  logic        [COEFF_W-1:0]  coeff,
    input  logic        [SAMPLE_W-1:0] sample,
    output logic signed [ACC_W-1:0]    result
);

    logic [PROD_W-1:0] product;

    // Unsigned 8x8 product, zero-extended so it is always subtracted as positive
    assign product = {{SAMPLE_W{1'b0}}, coeff} * {{COEFF_W{1'b0}}, sample};
    assign result  = acc - $signed({{(ACC_W-PROD_W){1'b0}}, product});

endmodule

// File: rtl/fir_deconvolver.sv
// Recovers x[n] from y[n] = x[n] + B1*x[n-1] + B2*x[n-2] + B3*x[n-3].
// One accepted y produces one x after three multiply-subtract cycles.
// Optional feature: define FIR_DECONV_ERR_EN to add the err output, which
// flags an accumulator outside 0..255 (input inconsistent with the filter).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; x_out/x_valid stay stable until x_ready is seen, y_ready is high
// only in IDLE and never while clear is asserted.
module fir_deconvolver
    import fir_pkg::*;
#(
    parameter logic [COEFF_W-1:0] B1 = DEF_B1,
    parameter logic [COEFF_W-1:0] B2 = DEF_B2,
    parameter logic [COEFF_W-1:0] B3 = DEF_B3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic [RESULT_W-1:0] y_in,
    input  logic                y_valid,
    output logic                y_ready,
    output logic [SAMPLE_W-1:0] x_out,
    output logic                x_valid,
    input  logic                x_ready,
    output logic [1:0]          fsm_state
`ifdef FIR_DECONV_ERR_EN
    ,
    output logic                err
`endif
);

    state_t                    state;
    state_t                    state_next;
    logic                      run_q;
    logic [1:0]                tap;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_next;
    logic [SAMPLE_W-1:0]       h0;
    logic [SAMPLE_W-1:0]       h1;
    logic [SAMPLE_W-1:0]       h2;
    logic [COEFF_W-1:0]        coeff;
    logic [SAMPLE_W-1:0]       sample;
    logic                      accept;
    logic                      mac_done;

    assign accept    = y_valid & y_ready;
    assign mac_done  = (state == ST_MAC) && (tap == TAP_LAST);
    assign fsm_state = state;

    // Goes high on the first edge after reset so y_ready stays low during reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) run_q <= 1'b0;
        else       run_q <= 1'b1;
    end

    // FSM state register; clear returns to IDLE ahead of any transition
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      state <= ST_IDLE;
        else if (clear) state <= ST_IDLE;
        else            state <= state_next;
    end

    // FSM next-state: IDLE -> MAC on accept, MAC -> OUT after tap 3, OUT -> IDLE on handshake
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept)   state_next = ST_MAC;
            ST_MAC:  if (mac_done) state_next = ST_OUT;
            ST_OUT:  if (x_ready)  state_next = ST_IDLE;
            default:               state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: ready only in IDLE (and not while flushing), valid only in OUT
    always_comb begin
        y_ready = (state == ST_IDLE) && run_q && !clear;
        x_valid = (state == ST_OUT);
    end

    // Select the coefficient / history pair for the current tap
    always_comb begin
        coeff  = '0;
        sample = '0;
        case (tap)
            2'd1: begin coeff = B1; sample = h0; end
            2'd2: begin coeff = B2; sample = h1; end
            2'd3: begin coeff = B3; sample = h2; end
            default: begin coeff = '0; sample = '0; end
        endcase
    end

    fir_mac_step u_mac_step (
        .acc    (acc),
        .coeff  (coeff),
        .sample (sample),
        .result (acc_next)
    );

    // Datapath: load y on accept, subtract one product per MAC cycle,
    // capture x on OUT entry and shift history on the output handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            tap   <= '0;
            x_out <= '0;
            h0    <= '0;
            h1    <= '0;
            h2    <= '0;
        end else if (clear) begin
            acc   <= '0;
            tap   <= '0;
            x_out <= '0;
            h0    <= '0;
            h1    <= '0;
            h2    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        acc <= $signed({{(ACC_W-RESULT_W){1'b0}}, y_in});
                        tap <= TAP_FIRST;
                    end
                end
                ST_MAC: begin
                    acc <= acc_next;
                    tap <= tap + 2'd1;
                    if (mac_done) x_out <= acc_next[SAMPLE_W-1:0];
                end
                ST_OUT: begin
                    if (x_ready) begin
                        h2 <= h1;
                        h1 <= h0;
                        h0 <= x_out;
                    end
                end
                default: begin
                    tap <= '0;
                end
            endcase
        end
    end

`ifdef FIR_DECONV_ERR_EN
    // Range flag captured together with x_out: final accumulator outside 0..255
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         err <= 1'b0;
        else if (clear)    err <= 1'b0;
        else if (mac_done) err <= acc_next[ACC_W-1] || (acc_next > ACC_X_MAX);
    end
`endif

endmodule

// File: doc/fir_deconvolver.md
FIR_DECONVOLVER -- requirements
Module: fir_deconvolver

Interface
REQ-001 SHALL have parameter B1, default 8'd2, meaning tap-1 coefficient (b0 is fixed at 1).
REQ-002 SHALL have parameter B2, default 8'd3, meaning tap-2 coefficient.
REQ-003 SHALL have parameter B3, default 8'd4, meaning tap-3 coefficient.
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port clear, input, 1 bit: synchronous flush of history and FSM.
REQ-007 SHALL have port y_in, input, 16 bits: filtered sample, unsigned.
REQ-008 SHALL have port y_valid, input, 1 bit: y_in is valid.
REQ-009 SHALL have port y_ready, output, 1 bit: block accepts y_in.
REQ-010 SHALL have port x_out, output, 8 bits: recovered sample.
REQ-011 SHALL have port x_valid, output, 1 bit: x_out is valid.
REQ-012 SHALL have port x_ready, input, 1 bit: downstream accepts x_out.

Function
REQ-013 SHALL invert y[n] = x[n] + B1*x[n-1] + B2*x[n-2] + B3*x[n-3] by computing x[n] = (y[n] - B1*h0 - B2*h1 - B3*h2) mod 256, where h0..h2 are the last three emitted x_out values.
REQ-014 SHALL use a signed accumulator of at least 20 bits; x_out SHALL be acc[7:0] (modular, exact for any legal 8-bit input stream).
REQ-015 SHALL implement states IDLE, MAC, OUT; transitions: IDLE->MAC on y_valid&y_ready; MAC->OUT after 3 cycles; OUT->IDLE on x_valid&x_ready.
REQ-016 SHALL assert y_ready only in IDLE, and x_valid only in OUT.
REQ-017 On accept in IDLE, SHALL load acc=y_in and set tap index to 1.
REQ-018 In MAC, SHALL subtract one product per cycle (B1*h0, then B2*h1, then B3*h2) using a single multiplier.
REQ-019 SHALL assert x_valid on the 3rd rising edge after the accept edge; the minimum sample period is 5 cycles.
REQ-020 SHALL hold x_out stable while x_valid=1 and x_ready=0 (unbounded backpressure).
REQ-021 On the output handshake, SHALL shift history: h2<=h1, h1<=h0, h0<=x_out.
REQ-022 SHALL give clear priority over every other event: history zeroed, state IDLE, x_valid=0, and any in-flight sample is discarded without an output.
REQ-023 y_in presented while not in IDLE SHALL be ignored and not consumed.

Reset
REQ-024 While reset=1, SHALL hold state=IDLE, h0..h2=0, acc=0, x_out=0, x_valid=0, and y_ready=0.
REQ-025 SHALL raise y_ready on the first clock edge after reset deasserts; reset mid-MAC or mid-OUT SHALL drop the sample.

Configuration
REQ-026 With macro FIR_DECONV_ERR_EN defined, SHALL add output err (1 bit), registered with x_out, high when acc<0 or acc>255 at OUT entry, meaning the input stream is inconsistent with the filter; err resets to 0.
REQ-027 Without FIR_DECONV_ERR_EN, err and its range-check logic SHALL be absent and behaviour is otherwise identical.

Structure
REQ-028 Package fir_pkg SHALL hold the sample width (8), result width (16), accumulator width (20), the state enum, and the default coefficients (1, 2, 3, 4) shared with the forward FIR.
REQ-029 SHALL contain one sub-module, fir_mac_step, that performs acc - coeff*sample combinationally; the FSM and history stay in the top module.

Verification
REQ-030 After reset with x_ready=1, feeding y=5, 17, 29, 296 SHALL produce x_out=5, 7, 0, 255, with err=0 for each sample.
REQ-031 After reset, feeding y=300 SHALL give x_out=44 and err=1.
REQ-032 After x=5 is emitted, feeding y=3 SHALL give acc=-7, x_out=8'hF9, and err=1.
REQ-033 With x_ready=0 for 10 cycles in OUT, SHALL keep x_out and x_valid stable and y_ready=0; the handshake SHALL occur on the first cycle x_ready=1.
REQ-034 Asserting clear (or reset) during MAC SHALL produce no x_valid; the next y=7 SHALL give x_out=7 (history zero).
REQ-035 Back-to-back y_valid held high SHALL be accepted exactly once per 5 cycles, with a 3-cycle accept-to-x_valid latency.
